// File: rtl/pkmc_wb_mem_bist_pkg.sv
// -----------------------------------------------------------------------------
// pkmc_wb_mem_bist_pkg
// Shared definitions for the PKMC Wishbone memory BIST:
//   - pattern mode encodings (mode 3 is reserved and behaves like mode 0)
//   - checkerboard constants for even / odd columns
//   - sweep FSM state encoding
//   - watchdog width and limit used when PKMC_BIST_TIMEOUT_EN is defined
// -----------------------------------------------------------------------------
package pkmc_wb_mem_bist_pkg;

  typedef enum logic [1:0] {
    MODE_ADDR = 2'd0,
    MODE_INV  = 2'd1,
    MODE_CHK  = 2'd2,
    MODE_RSVD = 2'd3
  } bist_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } bist_state_e;

  localparam logic [31:0] CHK_EVEN = 32'h5555_5555;
  localparam logic [31:0] CHK_ODD  = 32'hAAAA_AAAA;

  localparam int          WDOG_W     = 12;
  localparam logic [11:0] WDOG_LIMIT = 12'd4095;

endpackage

// File: rtl/pkmc_wb_mem_bist_addrgen.sv
// -----------------------------------------------------------------------------
// pkmc_wb_mem_bist_addrgen
// Bank/row/column sweep counters for the memory BIST.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   clr_i             : restart the sweep at bank 0, row 0, col 0
//   adv_i             : step to the next word of the current phase
//   rd_phase_i        : 1 while reading back; the bank only moves on after read
//   mode_i            : data pattern selector (bist_mode_e encoding)
//   adr_o             : Wishbone byte address {pad, bank, row, col, 2'b00}
//   exp_o             : pattern word for the current address
//   last_in_phase_o   : current word is the last column of the last tested row
//   last_bank_o       : current bank is the highest bank
// -----------------------------------------------------------------------------
module pkmc_wb_mem_bist_addrgen
  import pkmc_wb_mem_bist_pkg::*;
#(
  parameter int BANK_BITS   = 2,
  parameter int ROW_BITS    = 13,
  parameter int COL_BITS    = 9,
  parameter int ROWS_TESTED = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        adv_i,
  input  logic        rd_phase_i,
  input  logic [1:0]  mode_i,
  output logic [31:0] adr_o,
  output logic [31:0] exp_o,
  output logic        last_in_phase_o,
  output logic        last_bank_o
);

  localparam int AW = BANK_BITS + ROW_BITS + COL_BITS;

  localparam logic [ROW_BITS-1:0]  LAST_ROW = ROW_BITS'(ROWS_TESTED - 1);
  localparam logic [COL_BITS-1:0]  COL_MAX  = {COL_BITS{1'b1}};
  localparam logic [BANK_BITS-1:0] BANK_MAX = {BANK_BITS{1'b1}};
  localparam logic [BANK_BITS-1:0] BANK_ONE = BANK_BITS'(1);
  localparam logic [ROW_BITS-1:0]  ROW_ONE  = ROW_BITS'(1);
  localparam logic [COL_BITS-1:0]  COL_ONE  = COL_BITS'(1);

  logic [BANK_BITS-1:0] bank_q, bank_d;
  logic [ROW_BITS-1:0]  row_q,  row_d;
  logic [COL_BITS-1:0]  col_q,  col_d;
  logic [31:0]          word_s;

  // Next sweep position: column first, then row; bank moves only after read-back.
  always_comb begin
    bank_d = bank_q;
    row_d  = row_q;
    col_d  = col_q;
    if (clr_i) begin
      bank_d = {BANK_BITS{1'b0}};
      row_d  = {ROW_BITS{1'b0}};
      col_d  = {COL_BITS{1'b0}};
    end else if (adv_i) begin
      if (col_q == COL_MAX) begin
        col_d = {COL_BITS{1'b0}};
        if (row_q == LAST_ROW) begin
          row_d = {ROW_BITS{1'b0}};
          if (rd_phase_i) begin
            bank_d = bank_q + BANK_ONE;
          end else begin
            bank_d = bank_q;
          end
        end else begin
          row_d = row_q + ROW_ONE;
        end
      end else begin
        col_d = col_q + COL_ONE;
      end
    end else begin
      bank_d = bank_q;
      row_d  = row_q;
      col_d  = col_q;
    end
  end

  // Sweep position registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bank_q <= {BANK_BITS{1'b0}};
      row_q  <= {ROW_BITS{1'b0}};
      col_q  <= {COL_BITS{1'b0}};
    end else begin
      bank_q <= bank_d;
      row_q  <= row_d;
      col_q  <= col_d;
    end
  end

  // Word address; the geometry check in the top guarantees at least 2 pad bits.
  assign word_s = {{(32-AW){1'b0}}, bank_q, row_q, col_q};
  assign adr_o  = {word_s[29:0], 2'b00};

  // Pattern word for the current address; reserved mode falls back to address.
  always_comb begin
    exp_o = word_s;
    case (bist_mode_e'(mode_i))
      MODE_ADDR: exp_o = word_s;
      MODE_INV:  exp_o = ~word_s;
      MODE_CHK:  exp_o = col_q[0] ? CHK_ODD : CHK_EVEN;
      default:   exp_o = word_s;
    endcase
  end

  assign last_in_phase_o = (row_q == LAST_ROW) && (col_q == COL_MAX);
  assign last_bank_o     = (bank_q == BANK_MAX);

endmodule

// File: rtl/pkmc_wb_mem_bist.sv
// -----------------------------------------------------------------------------
// pkmc_wb_mem_bist
// Wishbone master that writes a pattern over ROWS_TESTED rows x all columns of
// each bank, reads it back and compares. Captures the first failure, counts
// mismatches (saturating) and reports pass/fail when done.
// Ports:
//   wb_clk_i, wb_rst_i         : clock, synchronous active-high reset
//   start_i, mode_i            : sweep start pulse and pattern mode
//   busy_o, done_o, pass_o     : sweep status
//   err_cnt_o                  : mismatch count
//   fail_adr/dat/exp_o         : first failure address, read data, expected data
//   wbm_*                      : classic Wishbone master interface
// Optional build macro PKMC_BIST_TIMEOUT_EN: a watchdog turns a strobe left
// without ack/err/rty for 4095 cycles into a bus error.
// -----------------------------------------------------------------------------
module pkmc_wb_mem_bist
  import pkmc_wb_mem_bist_pkg::*;
#(
  parameter int BANK_BITS   = 2,
  parameter int ROW_BITS    = 13,
  parameter int COL_BITS    = 9,
  parameter int ROWS_TESTED = 4,
  parameter int STOP_ON_ERR = 1,
  parameter int ERRCNT_W    = 16
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                start_i,
  input  logic [1:0]          mode_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                pass_o,
  output logic [ERRCNT_W-1:0] err_cnt_o,
  output logic [31:0]         fail_adr_o,
  output logic [31:0]         fail_dat_o,
  output logic [31:0]         fail_exp_o,
  output logic [31:0]         wbm_adr_o,
  output logic [31:0]         wbm_dat_o,
  output logic [3:0]          wbm_sel_o,
  output logic                wbm_we_o,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  input  logic [31:0]         wbm_dat_i,
  input  logic                wbm_ack_i,
  input  logic                wbm_err_i,
  input  logic                wbm_rty_i
);

  if ((BANK_BITS + ROW_BITS + COL_BITS) > 30 || ROWS_TESTED < 1 ||
      ROWS_TESTED > (2 ** ROW_BITS)) begin : g_bad_geometry
    $error("pkmc_wb_mem_bist: unsupported address geometry");
  end

  localparam logic                STOP_EN = (STOP_ON_ERR != 0);
  localparam logic [ERRCNT_W-1:0] ERR_ONE = ERRCNT_W'(1);
  localparam logic [ERRCNT_W-1:0] ERR_MAX = {ERRCNT_W{1'b1}};

  bist_state_e         state_q;
  logic [1:0]          mode_q;
  logic                cyc_q, stb_q, we_q;
  logic                busy_q, done_q, pass_q, fail_seen_q;
  logic [ERRCNT_W-1:0] err_cnt_q;
  logic [31:0]         fail_adr_q, fail_dat_q, fail_exp_q;

  logic        req_s, ack_s, rty_s, buserr_s, to_s;
  logic        mismatch_s, stop_s, adv_s, start_s, rd_phase_s;
  logic        last_s, last_bank_s;
  logic [31:0] adr_s, exp_s;

  // Response decode with priority err > ack > rty; only a live strobe counts.
  assign req_s      = cyc_q & stb_q;
  assign buserr_s   = req_s & (wbm_err_i | to_s);
  assign ack_s      = req_s & ~wbm_err_i & wbm_ack_i;
  assign rty_s      = req_s & ~wbm_err_i & ~wbm_ack_i & wbm_rty_i;
  assign mismatch_s = ack_s & ~we_q & (wbm_dat_i != exp_s);
  assign stop_s     = mismatch_s & STOP_EN;
  // A stopping mismatch leaves the address on the failing word.
  assign adv_s      = ack_s & ~stop_s;
  assign start_s    = start_i & ~busy_q;
  assign rd_phase_s = ~we_q;

  pkmc_wb_mem_bist_addrgen #(
    .BANK_BITS  (BANK_BITS),
    .ROW_BITS   (ROW_BITS),
    .COL_BITS   (COL_BITS),
    .ROWS_TESTED(ROWS_TESTED)
  ) u_addrgen (
    .clk_i          (wb_clk_i),
    .rst_i          (wb_rst_i),
    .clr_i          (start_s),
    .adv_i          (adv_s),
    .rd_phase_i     (rd_phase_s),
    .mode_i         (mode_q),
    .adr_o          (adr_s),
    .exp_o          (exp_s),
    .last_in_phase_o(last_s),
    .last_bank_o    (last_bank_s)
  );

`ifdef PKMC_BIST_TIMEOUT_EN
  logic [WDOG_W-1:0] wdog_q;
  logic              stall_s;

  assign stall_s = req_s & ~wbm_ack_i & ~wbm_err_i & ~wbm_rty_i;
  // Fires on the 4095th consecutive stalled cycle.
  assign to_s    = stall_s & (wdog_q == (WDOG_LIMIT - 12'd1));

  // Watchdog: counts consecutive stalled strobe cycles.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wdog_q <= {WDOG_W{1'b0}};
    end else if (stall_s) begin
      wdog_q <= wdog_q + 12'd1;
    end else begin
      wdog_q <= {WDOG_W{1'b0}};
    end
  end
`else
  assign to_s = 1'b0;
`endif

  // Sweep FSM with registered bus controls, status and failure capture.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_IDLE;
      mode_q      <= 2'd0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_seen_q <= 1'b0;
      err_cnt_q   <= {ERRCNT_W{1'b0}};
      fail_adr_q  <= 32'h0;
      fail_dat_q  <= 32'h0;
      fail_exp_q  <= 32'h0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            state_q     <= ST_WRITE;
            mode_q      <= mode_i;
            cyc_q       <= 1'b1;
            stb_q       <= 1'b1;
            we_q        <= 1'b1;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_seen_q <= 1'b0;
            err_cnt_q   <= {ERRCNT_W{1'b0}};
            fail_adr_q  <= 32'h0;
            fail_dat_q  <= 32'h0;
            fail_exp_q  <= 32'h0;
          end
        end
        ST_WRITE, ST_READ: begin
          if (buserr_s) begin
            if (!fail_seen_q) begin
              fail_seen_q <= 1'b1;
              fail_adr_q  <= adr_s;
              fail_dat_q  <= wbm_dat_i;
              fail_exp_q  <= exp_s;
            end
            state_q <= ST_DONE;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= 1'b0;
          end else if (ack_s) begin
            if (mismatch_s) begin
              if (!fail_seen_q) begin
                fail_seen_q <= 1'b1;
                fail_adr_q  <= adr_s;
                fail_dat_q  <= wbm_dat_i;
                fail_exp_q  <= exp_s;
              end
              if (err_cnt_q != ERR_MAX) begin
                err_cnt_q <= err_cnt_q + ERR_ONE;
              end
            end
            if (stop_s || (last_s && state_q == ST_READ && last_bank_s)) begin
              state_q <= ST_DONE;
              cyc_q   <= 1'b0;
              stb_q   <= 1'b0;
              we_q    <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= ~(fail_seen_q | mismatch_s);
            end else if (last_s) begin
              // Write phase hands over to read-back of the same bank; read
              // phase moves on to writing the next bank.
              state_q <= (state_q == ST_WRITE) ? ST_READ : ST_WRITE;
              we_q    <= (state_q != ST_WRITE);
            end
          end else if (rty_s) begin
            stb_q <= 1'b0;
          end else if (!stb_q) begin
            // One-cycle gap after a retry is over: reissue the same access.
            stb_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cyc_q   <= 1'b0;
          stb_q   <= 1'b0;
          we_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign pass_o     = pass_q;
  assign err_cnt_o  = err_cnt_q;
  assign fail_adr_o = fail_adr_q;
  assign fail_dat_o = fail_dat_q;
  assign fail_exp_o = fail_exp_q;
  assign wbm_adr_o  = adr_s;
  assign wbm_dat_o  = we_q ? exp_s : 32'h0;
  assign wbm_sel_o  = {4{cyc_q}};
  assign wbm_we_o   = we_q;
  assign wbm_cyc_o  = cyc_q;
  assign wbm_stb_o  = stb_q;

endmodule

// File: tb/tb_pkmc_wb_mem_bist.sv
// -----------------------------------------------------------------------------
// tb_pkmc_wb_mem_bist
// Two BIST instances (STOP_ON_ERR=1 and 0) with a small geometry share one
// behavioural zero-wait Wishbone memory slave; only one instance runs at a
// time. A table of sweeps is applied in a loop, followed by hand-written
// retry, reset-mid-read and (with PKMC_BIST_TIMEOUT_EN) watchdog sequences.
// -----------------------------------------------------------------------------
module tb_pkmc_wb_mem_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       start_a = 1'b0, start_b = 1'b0, use_b = 1'b0;
  logic [1:0] mode = 2'd0;

  logic busy_a, done_a, pass_a, we_a, cyc_a, stb_a;
  logic busy_b, done_b, pass_b, we_b, cyc_b, stb_b;
  logic [15:0] ecnt_a, ecnt_b;
  logic [31:0] fadr_a, fdat_a, fexp_a, adr_a, dat_a;
  logic [31:0] fadr_b, fdat_b, fexp_b, adr_b, dat_b;
  logic [3:0]  sel_a, sel_b;

  logic        s_ack, s_err, s_rty;
  logic [31:0] s_dat;

  pkmc_wb_mem_bist #(.BANK_BITS(2), .ROW_BITS(2), .COL_BITS(3), .ROWS_TESTED(4),
                     .STOP_ON_ERR(1), .ERRCNT_W(16)) dut_a (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start_a), .mode_i(mode),
    .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a), .err_cnt_o(ecnt_a),
    .fail_adr_o(fadr_a), .fail_dat_o(fdat_a), .fail_exp_o(fexp_a),
    .wbm_adr_o(adr_a), .wbm_dat_o(dat_a), .wbm_sel_o(sel_a), .wbm_we_o(we_a),
    .wbm_cyc_o(cyc_a), .wbm_stb_o(stb_a), .wbm_dat_i(s_dat),
    .wbm_ack_i(s_ack & ~use_b), .wbm_err_i(s_err & ~use_b), .wbm_rty_i(s_rty & ~use_b));

  pkmc_wb_mem_bist #(.BANK_BITS(2), .ROW_BITS(2), .COL_BITS(3), .ROWS_TESTED(4),
                     .STOP_ON_ERR(0), .ERRCNT_W(16)) dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start_b), .mode_i(mode),
    .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b), .err_cnt_o(ecnt_b),
    .fail_adr_o(fadr_b), .fail_dat_o(fdat_b), .fail_exp_o(fexp_b),
    .wbm_adr_o(adr_b), .wbm_dat_o(dat_b), .wbm_sel_o(sel_b), .wbm_we_o(we_b),
    .wbm_cyc_o(cyc_b), .wbm_stb_o(stb_b), .wbm_dat_i(s_dat),
    .wbm_ack_i(s_ack & use_b), .wbm_err_i(s_err & use_b), .wbm_rty_i(s_rty & use_b));

  // Selected instance view
  logic        m_busy, m_done, m_pass, m_we, m_cyc, m_stb;
  logic [15:0] m_ecnt;
  logic [31:0] m_fadr, m_fdat, m_fexp, m_adr, m_dat;
  logic [3:0]  m_sel;
  assign m_busy = use_b ? busy_b : busy_a;
  assign m_done = use_b ? done_b : done_a;
  assign m_pass = use_b ? pass_b : pass_a;
  assign m_we   = use_b ? we_b   : we_a;
  assign m_cyc  = use_b ? cyc_b  : cyc_a;
  assign m_stb  = use_b ? stb_b  : stb_a;
  assign m_ecnt = use_b ? ecnt_b : ecnt_a;
  assign m_fadr = use_b ? fadr_b : fadr_a;
  assign m_fdat = use_b ? fdat_b : fdat_a;
  assign m_fexp = use_b ? fexp_b : fexp_a;
  assign m_adr  = use_b ? adr_b  : adr_a;
  assign m_dat  = use_b ? dat_b  : dat_a;
  assign m_sel  = use_b ? sel_b  : sel_a;

  // Behavioural slave: 128 words, ack in the strobe cycle, injectable faults
  logic [31:0] mem [128];
  logic [31:0] corr [3];
  int          ncorr = 0, rty_n = 0, err_at = -1;
  logic        stall = 1'b0, slv_clr = 1'b0;
  int          acc_cnt = 0, rty_cnt = 0;
  logic        hit_s;
  logic [6:0]  widx;

  assign widx = m_adr[8:2];

  always_comb begin
    hit_s = 1'b0;
    for (int i = 0; i < 3; i++)
      if (i < ncorr && m_adr == corr[i]) hit_s = 1'b1;
  end

  assign s_dat = mem[widx] ^ {31'b0, hit_s};

  always_comb begin
    s_ack = 1'b0;
    s_err = 1'b0;
    s_rty = 1'b0;
    if (m_cyc && m_stb && !stall) begin
      if (err_at >= 0 && acc_cnt == err_at) s_err = 1'b1;
      else if (rty_cnt < rty_n)             s_rty = 1'b1;
      else                                  s_ack = 1'b1;
    end
  end

  always @(posedge clk) begin
    if (slv_clr) begin
      acc_cnt <= 0;
      rty_cnt <= 0;
    end else begin
      if (s_ack) begin
        acc_cnt <= acc_cnt + 1;
        if (m_we) mem[widx] <= m_dat;
      end
      if (s_rty) rty_cnt <= rty_cnt + 1;
    end
  end

  // Checking
  int nvec = 0, nfail = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic slave_cfg(input int nc, input logic [31:0] c0, input logic [31:0] c1,
                           input logic [31:0] c2, input int ea, input int rn,
                           input logic st);
    @(negedge clk);
    ncorr = nc; corr[0] = c0; corr[1] = c1; corr[2] = c2;
    err_at = ea; rty_n = rn; stall = st;
    slv_clr = 1'b1;
    @(negedge clk);
    slv_clr = 1'b0;
  endtask

  // Start pulse sampled on one edge; returns at the falling edge after it.
  task automatic pulse_start();
    start_a = ~use_b;
    start_b = use_b;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input int lim, output int n);
    n = 0;
    while (!m_done && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (!m_done) begin
      nfail++;
      $display("FAIL done_timeout: done_o still 0 after %0d cycles", n);
    end
  endtask

  typedef struct {
    logic        use_b;
    logic [1:0]  mode;
    int          ncorr;
    logic [31:0] c0, c1, c2;
    int          err_at;
    int          cyc;
    logic        pass;
    int          ecnt;
    logic [31:0] fadr, fdat, fexp;
    int          pidx;
    logic [31:0] pval;
  } vec_t;

  vec_t vt [7];

  initial begin
    int n;

    vt[0] = '{1'b0, 2'd0, 0, 32'h0, 32'h0, 32'h0, -1, 256, 1'b1, 0, 32'h0, 32'h0, 32'h0, 'h4D, 32'h0000_004D};
    vt[1] = '{1'b0, 2'd1, 0, 32'h0, 32'h0, 32'h0, -1, 256, 1'b1, 0, 32'h0, 32'h0, 32'h0, 3, 32'hFFFF_FFFC};
    vt[2] = '{1'b0, 2'd2, 0, 32'h0, 32'h0, 32'h0, -1, 256, 1'b1, 0, 32'h0, 32'h0, 32'h0, 3, 32'hAAAA_AAAA};
    vt[3] = '{1'b0, 2'd3, 0, 32'h0, 32'h0, 32'h0, -1, 256, 1'b1, 0, 32'h0, 32'h0, 32'h0, 'h4D, 32'h0000_004D};
    vt[4] = '{1'b0, 2'd0, 1, 32'h134, 32'h0, 32'h0, -1, 174, 1'b0, 1, 32'h134, 32'h4C, 32'h4D, 'h4D, 32'h0000_004D};
    vt[5] = '{1'b1, 2'd0, 3, 32'h134, 32'h008, 32'h1FC, -1, 256, 1'b0, 3, 32'h8, 32'h3, 32'h2, 'h7F, 32'h0000_007F};
    vt[6] = '{1'b0, 2'd0, 0, 32'h0, 32'h0, 32'h0, 9, 10, 1'b0, 0, 32'h24, 32'h9, 32'h9, 8, 32'h0000_0008};

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 0, {31'b0, busy_a}, 32'h0);
    chk("rst_done", 0, {31'b0, done_a}, 32'h0);
    chk("rst_pass", 0, {31'b0, pass_a}, 32'h0);
    chk("rst_ecnt", 0, {16'b0, ecnt_a}, 32'h0);
    chk("rst_fadr", 0, fadr_a, 32'h0);
    chk("rst_bus",  0, {27'b0, cyc_a, stb_a, we_a, |sel_a, |dat_a}, 32'h0);
    chk("rst_adr",  0, adr_a, 32'h0);
    chk("rst_b",    0, {30'b0, cyc_b, done_b}, 32'h0);

    // Table-driven sweeps
    for (int v = 0; v < 7; v++) begin
      use_b = vt[v].use_b;
      mode  = vt[v].mode;
      slave_cfg(vt[v].ncorr, vt[v].c0, vt[v].c1, vt[v].c2, vt[v].err_at, 0, 1'b0);
      pulse_start();
      wait_done(2000, n);
      chk("cycles",   v, n, vt[v].cyc);
      chk("pass",     v, {31'b0, m_pass}, {31'b0, vt[v].pass});
      chk("busy",     v, {31'b0, m_busy}, 32'h0);
      chk("err_cnt",  v, {16'b0, m_ecnt}, vt[v].ecnt);
      chk("fail_adr", v, m_fadr, vt[v].fadr);
      chk("fail_dat", v, m_fdat, vt[v].fdat);
      chk("fail_exp", v, m_fexp, vt[v].fexp);
      chk("mem_word", v, mem[vt[v].pidx], vt[v].pval);
    end

    // Two retries on the first write
    use_b = 1'b0;
    mode  = 2'd0;
    slave_cfg(0, 32'h0, 32'h0, 32'h0, -1, 2, 1'b0);
    pulse_start();
    @(negedge clk); chk("rty_gap1", 0, {30'b0, m_cyc, m_stb}, 32'h2);
    @(negedge clk); chk("rty_re1",  0, {31'b0, m_stb}, 32'h1);
                    chk("rty_adr1", 0, m_adr, 32'h0);
    @(negedge clk); chk("rty_gap2", 0, {31'b0, m_stb}, 32'h0);
    @(negedge clk); chk("rty_re2",  0, {30'b0, m_stb, m_we}, 32'h3);
                    chk("rty_adr2", 0, m_adr, 32'h0);
    @(negedge clk); chk("rty_next", 0, m_adr, 32'h4);
    wait_done(2000, n);
    chk("rty_pass", 0, {31'b0, m_pass}, 32'h1);

    // Start while busy is ignored, then reset in the read phase
    slave_cfg(0, 32'h0, 32'h0, 32'h0, -1, 0, 1'b0);
    pulse_start();
    repeat (20) @(negedge clk);
    pulse_start();
    repeat (19) @(negedge clk);
    chk("mid_adr",  0, m_adr, 32'h20);
    chk("mid_stat", 0, {30'b0, m_busy, m_we}, 32'h2);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_bus",  0, {27'b0, m_cyc, m_stb, m_we, |m_sel, |m_dat}, 32'h0);
    chk("mrst_stat", 0, {29'b0, m_busy, m_done, m_pass}, 32'h0);
    chk("mrst_adr",  0, m_adr, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    pulse_start();
    wait_done(2000, n);
    chk("post_rst_cycles", 0, n, 256);
    chk("post_rst_pass",   0, {31'b0, m_pass}, 32'h1);

`ifdef PKMC_BIST_TIMEOUT_EN
    // Slave never responds: watchdog ends the sweep
    slave_cfg(0, 32'h0, 32'h0, 32'h0, -1, 0, 1'b1);
    pulse_start();
    wait_done(6000, n);
    chk("wdog_cycles", 0, n, 4095);
    chk("wdog_pass",   0, {31'b0, m_pass}, 32'h0);
    chk("wdog_fadr",   0, m_fadr, 32'h0);
    slave_cfg(0, 32'h0, 32'h0, 32'h0, -1, 0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
